// File: rtl/main_mem_responder.sv
// Word-addressed memory responder: posted zero-wait writes, fixed-latency reads with a one-cycle ready pulse.
// Optional MEM_BURST_EN macro enables a one-cycle fast path for sequential reads within a 16-byte line.
module main_mem_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // Cycles spent in WAIT after the accept edge; latency 1 bypasses WAIT entirely.
    localparam logic [3:0] CNT_LOAD = (READ_LATENCY >= 2) ? 4'(READ_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic [3:0]     cnt_nxt;
    logic [31:0]    cap_addr;
    logic [31:0]    cap_nxt;
    logic           load_rdata;
    logic           fast_accept;
    logic           ready_nxt;
    logic [31:0]    rdata_nxt;
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic [31:0]    mem [DEPTH_WORDS];

    assign wr_idx = mem_addr[AW+1:2];
    assign rd_idx = (state == IDLE) ? mem_addr[AW+1:2] : cap_addr[AW+1:2];

    // Storage is deliberately not reset so contents survive reset_n.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_idx] <= mem_wdata;
        end
    end

`ifdef MEM_BURST_EN
    logic [31:0] last_addr;
    logic [31:0] seq_addr;
    logic        resp_d;

    assign seq_addr    = last_addr + 32'd4;
    assign fast_accept = (READ_LATENCY == 1) ||
                         (resp_d && (mem_addr == seq_addr) && (mem_addr[31:4] == last_addr[31:4]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_addr <= '0;
            resp_d    <= 1'b0;
        end else begin
            resp_d <= (state == RESP);
            if (load_rdata) begin
                last_addr <= (state == IDLE) ? mem_addr : cap_addr;
            end
        end
    end
`else
    assign fast_accept = (READ_LATENCY == 1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cap_addr <= cap_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cap_nxt    = cap_addr;
        load_rdata = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    cap_nxt = mem_addr;
                    if (fast_accept) begin
                        state_nxt  = RESP;
                        load_rdata = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!mem_read) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (mem_addr != cap_addr) begin
                    cap_nxt = mem_addr;
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt  = RESP;
                    load_rdata = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A write landing on the word being returned at the same edge is forwarded.
    always_comb begin
        ready_nxt = load_rdata;
        rdata_nxt = mem_rdata;
        if (load_rdata) begin
            rdata_nxt = (mem_write && (wr_idx == rd_idx)) ? mem_wdata : mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= ready_nxt;
            mem_rdata <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: per-cycle vector table plus hand-written abort/restart/reset sequences.
module tb_main_mem_responder;

`ifdef MEM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int unsigned errors;
    int unsigned checks;
    logic [31:0] expd;
    vec_t        vecs[$];

    main_mem_responder #(
        .DEPTH_WORDS (1024),
        .READ_LATENCY(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic er, input logic [31:0] ed, input string nm);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        @(negedge clk);
        check({nm, " ready"}, {31'd0, mem_ready}, {31'd0, er});
        check({nm, " rdata"}, mem_rdata, ed);
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic er, input logic [31:0] ed, input string nm);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd;
        v.exp_ready = er; v.exp_rdata = ed; v.name = nm;
        vecs.push_back(v);
    endtask

    // Held read of addr: ready in the L-th cycle after first presentation, carrying data.
    task automatic add_read(input logic [31:0] addr, input int unsigned lat, input logic [31:0] data,
                            input string nm);
        for (int unsigned c = 0; c < lat; c++) row(1'b1, 1'b0, addr, '0, 1'b0, expd, nm);
        row(1'b1, 1'b0, addr, '0, 1'b1, data, nm);
        expd = data;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        expd      = '0;
        reset_n   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {31'd0, mem_ready}, 32'd0);
        check("reset rdata", mem_rdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // basic latency
        row(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, expd, "basic_wr");
        add_read(32'h10, 3, 32'hDEADBEEF, "basic_rd");
        row(1'b0, 1'b0, '0, '0, 1'b0, expd, "basic_idle");
        // upper address bits alias
        row(1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0, expd, "alias_wr");
        add_read(32'h1010, 3, 32'h12345678, "alias_rd");
        row(1'b0, 1'b0, '0, '0, 1'b0, expd, "alias_idle");
        // 4-word refill, address advanced after each ready
        for (int unsigned w = 0; w < 5; w++)
            row(1'b0, 1'b1, 32'h200 + 32'(4 * w), 32'hB000_0000 + 32'(w), 1'b0, expd, "refill_wr");
        for (int unsigned w = 0; w < 4; w++)
            add_read(32'h200 + 32'(4 * w), (BURST && w > 0) ? 1 : 3, 32'hB000_0000 + 32'(w), "refill_rd");
        // sequential but crossing the 16-byte line: never fast
        add_read(32'h210, 3, 32'hB000_0004, "line_cross_rd");
        row(1'b0, 1'b0, '0, '0, 1'b0, expd, "refill_idle");
        // simultaneous write+read at accept, then forwarding at the load edge
        row(1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0, expd, "fwd_c0");
        row(1'b1, 1'b0, 32'h20, '0, 1'b0, expd, "fwd_c1");
        row(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, expd, "fwd_c2");
        row(1'b1, 1'b0, 32'h20, '0, 1'b1, 32'hCAFEF00D, "fwd_c3");
        expd = 32'hCAFEF00D;
        row(1'b0, 1'b0, '0, '0, 1'b0, expd, "fwd_idle");

        foreach (vecs[i])
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_ready, vecs[i].exp_rdata, vecs[i].name);

        // abort: drop mem_read in cycle 2, no pulse through cycle 10
        step(1'b1, 1'b0, 32'h40, '0, 1'b0, expd, "abort_c0");
        step(1'b1, 1'b0, 32'h40, '0, 1'b0, expd, "abort_c1");
        for (int c = 2; c <= 10; c++) step(1'b0, 1'b0, 32'h40, '0, 1'b0, expd, "abort_tail");

        // address change during WAIT restarts the count from cycle 2
        step(1'b1, 1'b0, 32'h10, '0, 1'b0, expd, "restart_c0");
        step(1'b1, 1'b0, 32'h10, '0, 1'b0, expd, "restart_c1");
        for (int c = 2; c <= 4; c++) step(1'b1, 1'b0, 32'h20, '0, 1'b0, expd, "restart_wait");
        step(1'b1, 1'b0, 32'h20, '0, 1'b1, 32'hCAFEF00D, "restart_rdy");
        step(1'b0, 1'b0, '0, '0, 1'b0, expd, "restart_idle");

        // reset mid-read drops it; storage survives
        step(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 1'b0, expd, "rst_wr");
        step(1'b1, 1'b0, 32'h80, '0, 1'b0, expd, "rst_c0");
        reset_n = 1'b0;
        #1;
        check("rst_async ready", {31'd0, mem_ready}, 32'd0);
        check("rst_async rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expd = '0;
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h80, '0, 1'b0, expd, "rst_nopulse");
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h80, '0, 1'b0, expd, "rst_rd");
        step(1'b1, 1'b0, 32'h80, '0, 1'b1, 32'hA5A5A5A5, "rst_rd_rdy");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
